// File: rtl/axis_flit_deserializer.sv
// axis_flit_deserializer: NoC egress endpoint. Buffers credit-flow-controlled
// flits in a small FIFO, returns one credit per consumed flit and reassembles
// SERIALIZATION_FACTOR flits (least-significant first) into one AXI-Stream beat.
module axis_flit_deserializer #(
  parameter int TDATA_WIDTH          = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int TDEST_WIDTH          = 6,
  parameter int TUSER_WIDTH          = 32,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0]  data_in,
  input  logic [TDEST_WIDTH-1:0]                       dest_in,
  input  logic [TUSER_WIDTH-1:0]                       user_in,
  input  logic                                         is_tail_in,
  input  logic                                         send_in,
  output logic                                         credit_out,
  output logic                                         axis_tvalid,
  input  logic                                         axis_tready,
  output logic [TDATA_WIDTH-1:0]                       axis_tdata,
  output logic                                         axis_tlast,
  output logic [TUSER_WIDTH-1:0]                       axis_tuser,
  output logic [TDEST_WIDTH-1:0]                       axis_tdest,
  output logic                                         overflow_err
);

  localparam int FLIT_WIDTH  = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int ENTRY_WIDTH = FLIT_WIDTH + TDEST_WIDTH + TUSER_WIDTH + 1;
  localparam int PTR_WIDTH   = $clog2(FLIT_BUFFER_DEPTH);
  localparam int FILL_WIDTH  = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int CNT_WIDTH   = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

  localparam logic [PTR_WIDTH-1:0]  PTR_LAST  = PTR_WIDTH'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [FILL_WIDTH-1:0] FILL_FULL = FILL_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(SERIALIZATION_FACTOR - 1);

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return {PTR_WIDTH{1'b0}};
    end else begin
      return ptr + PTR_WIDTH'(1);
    end
  endfunction

  // FIFO storage and bookkeeping
  logic [ENTRY_WIDTH-1:0] fifo_mem_r [FLIT_BUFFER_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_r;
  logic [PTR_WIDTH-1:0]   rd_ptr_r;
  logic [FILL_WIDTH-1:0]  fill_r;

  // Head-of-FIFO flit fields
  logic [FLIT_WIDTH-1:0]  head_data_s;
  logic [TDEST_WIDTH-1:0] head_dest_s;
  logic [TUSER_WIDTH-1:0] head_user_s;
  logic                   head_tail_s;

  // Assembler state
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [TDATA_WIDTH-1:0] acc_data_r;
  logic [TDEST_WIDTH-1:0] acc_dest_r;
  logic [TUSER_WIDTH-1:0] acc_user_r;
  logic                   acc_last_r;
  logic                   beat_done_r;

  // Control
  logic empty_s;
  logic full_s;
  logic out_free_s;
  logic load_s;
  logic head_completes_s;
  logic pop_s;
  logic write_s;
  logic overflow_s;

  assign {head_data_s, head_dest_s, head_user_s, head_tail_s} = fifo_mem_r[rd_ptr_r];

  // Pop/write arbitration. A flit that completes a beat is only taken when
  // the output register can accept that beat on the following edge, which
  // also covers an early tail arriving while the output is stalled.
  always_comb begin
    empty_s          = (fill_r == {FILL_WIDTH{1'b0}});
    full_s           = (fill_r == FILL_FULL);
    out_free_s       = !axis_tvalid || axis_tready;
    load_s           = beat_done_r && out_free_s;
    head_completes_s = (cnt_r == CNT_LAST) || head_tail_s;
    if (empty_s) begin
      pop_s = 1'b0;
    end else if (beat_done_r && !load_s) begin
      pop_s = 1'b0;
    end else if (head_completes_s) begin
      pop_s = out_free_s;
    end else begin
      pop_s = 1'b1;
    end
    write_s    = send_in && (!full_s || pop_s);
    overflow_s = send_in && full_s && !pop_s;
  end

  // FIFO data storage (contents are only observed while occupied).
  always_ff @(posedge clk) begin
    if (write_s) begin
      fifo_mem_r[wr_ptr_r] <= {data_in, dest_in, user_in, is_tail_in};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_WIDTH{1'b0}};
      rd_ptr_r <= {PTR_WIDTH{1'b0}};
      fill_r   <= {FILL_WIDTH{1'b0}};
    end else begin
      if (write_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({write_s, pop_s})
        2'b10:   fill_r <= fill_r + FILL_WIDTH'(1);
        2'b01:   fill_r <= fill_r - FILL_WIDTH'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Beat assembly: place each popped flit in its slice, flag completed beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_WIDTH{1'b0}};
      acc_data_r  <= {TDATA_WIDTH{1'b0}};
      acc_dest_r  <= {TDEST_WIDTH{1'b0}};
      acc_user_r  <= {TUSER_WIDTH{1'b0}};
      acc_last_r  <= 1'b0;
      beat_done_r <= 1'b0;
    end else begin
      if (pop_s) begin
        if (cnt_r == {CNT_WIDTH{1'b0}}) begin
          // First flit clears the upper slices so short beats read as zero.
          acc_data_r <= TDATA_WIDTH'(head_data_s);
          acc_dest_r <= head_dest_s;
          acc_user_r <= head_user_s;
        end else begin
          acc_data_r[int'(cnt_r) * FLIT_WIDTH +: FLIT_WIDTH] <= head_data_s;
        end
        if (head_completes_s) begin
          cnt_r       <= {CNT_WIDTH{1'b0}};
          acc_last_r  <= head_tail_s;
          beat_done_r <= 1'b1;
        end else begin
          cnt_r       <= cnt_r + CNT_WIDTH'(1);
          beat_done_r <= 1'b0;
        end
      end else if (load_s) begin
        beat_done_r <= 1'b0;
      end
    end
  end

  // Output register, credit return and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axis_tvalid  <= 1'b0;
      axis_tdata   <= {TDATA_WIDTH{1'b0}};
      axis_tlast   <= 1'b0;
      axis_tuser   <= {TUSER_WIDTH{1'b0}};
      axis_tdest   <= {TDEST_WIDTH{1'b0}};
      credit_out   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (load_s) begin
        axis_tvalid <= 1'b1;
        axis_tdata  <= acc_data_r;
        axis_tlast  <= acc_last_r;
        axis_tuser  <= acc_user_r;
        axis_tdest  <= acc_dest_r;
      end else if (axis_tvalid && axis_tready) begin
        axis_tvalid <= 1'b0;
      end
      credit_out <= pop_s;
      if (overflow_s) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Self-checking bench for axis_flit_deserializer: random flit traffic under
// credit discipline, checked against a flit-queue reference model.
module tb_axis_flit_deserializer;

  localparam int TDW   = 512;
  localparam int SF    = 4;
  localparam int DW    = 6;
  localparam int UW    = 32;
  localparam int DEPTH = 4;
  localparam int FW    = TDW / SF;

  typedef struct {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic [UW-1:0] user;
    logic          tail;
  } flit_t;

  typedef struct {
    logic [TDW-1:0] data;
    logic           last;
    logic [DW-1:0]  dest;
    logic [UW-1:0]  user;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [FW-1:0]  data_in;
  logic [DW-1:0]  dest_in;
  logic [UW-1:0]  user_in;
  logic           is_tail_in;
  logic           send_in;
  logic           credit_out;
  logic           axis_tvalid;
  logic           axis_tready;
  logic [TDW-1:0] axis_tdata;
  logic           axis_tlast;
  logic [UW-1:0]  axis_tuser;
  logic [DW-1:0]  axis_tdest;
  logic           overflow_err;

  flit_t cur_q[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    exp_rd = 0;
  int    obs_rd = 0;
  int    credit_pulses = 0;
  int    credit_base = 0;
  int    sent_cnt = 0;
  int    sent_base = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  axis_flit_deserializer #(
    .TDATA_WIDTH(TDW), .SERIALIZATION_FACTOR(SF), .TDEST_WIDTH(DW),
    .TUSER_WIDTH(UW), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .user_in(user_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
    .axis_tdata(axis_tdata), .axis_tlast(axis_tlast), .axis_tuser(axis_tuser),
    .axis_tdest(axis_tdest), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Monitor: count credit pulses and record accepted beats on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (credit_out) credit_pulses++;
      if (axis_tvalid && axis_tready) begin
        b.data = axis_tdata;
        b.last = axis_tlast;
        b.dest = axis_tdest;
        b.user = axis_tuser;
        obs_q.push_back(b);
      end
    end
  end

  function automatic int credits_avail();
    return DEPTH + (credit_pulses - credit_base) - (sent_cnt - sent_base);
  endfunction

  function automatic flit_t rand_flit(input logic tail);
    flit_t f;
    f.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    f.dest = DW'($urandom());
    f.user = $urandom();
    f.tail = tail;
    return f;
  endfunction

  // Reference model: collect flits, emit a beat after SF flits or on a tail.
  task automatic model_accept(input flit_t f);
    beat_t b;
    cur_q.push_back(f);
    if (cur_q.size() == SF || f.tail) begin
      b.data = '0;
      for (int i = 0; i < cur_q.size(); i++)
        b.data = b.data | (TDW'(cur_q[i].data) << (i * FW));
      b.last = f.tail;
      b.dest = cur_q[0].dest;
      b.user = cur_q[0].user;
      exp_q.push_back(b);
      cur_q.delete();
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one flit for one edge; when obeying credits, wait for one first.
  task automatic send_flit(input flit_t f, input bit obey);
    int waited = 0;
    if (obey) begin
      while (credits_avail() <= 0 && waited < 500) begin
        cycles(1);
        waited++;
      end
      n_checks++;
      if (credits_avail() <= 0) begin
        n_errors++;
        $display("FAIL credit_wait: credits available %0d after %0d cycles, need >0", credits_avail(), waited);
      end
    end
    data_in    = f.data;
    dest_in    = f.dest;
    user_in    = f.user;
    is_tail_in = f.tail;
    send_in    = 1'b1;
    @(posedge clk);
    #1;
    send_in    = 1'b0;
    is_tail_in = 1'b0;
    if (obey) begin
      sent_cnt++;
      model_accept(f);
    end
  endtask

  // Wait for all modelled beats, then compare them in order.
  task automatic check_beats(input string name, input int budget);
    int waited = 0;
    while ((obs_q.size() - obs_rd) < (exp_q.size() - exp_rd) && waited < budget) begin
      cycles(1);
      waited++;
    end
    cycles(4);
    n_checks++;
    if ((obs_q.size() - obs_rd) != (exp_q.size() - exp_rd)) begin
      n_errors++;
      $display("FAIL %s_beat_count: got %0d beats, expected %0d", name, obs_q.size() - obs_rd, exp_q.size() - exp_rd);
    end
    while (exp_rd < exp_q.size()) begin
      if (obs_rd < obs_q.size()) begin
        n_checks += 4;
        if (obs_q[obs_rd].data !== exp_q[exp_rd].data) begin
          n_errors++;
          $display("FAIL %s_tdata[%0d]: got %h expected %h", name, exp_rd, obs_q[obs_rd].data, exp_q[exp_rd].data);
        end
        if (obs_q[obs_rd].last !== exp_q[exp_rd].last) begin
          n_errors++;
          $display("FAIL %s_tlast[%0d]: got %b expected %b", name, exp_rd, obs_q[obs_rd].last, exp_q[exp_rd].last);
        end
        if (obs_q[obs_rd].dest !== exp_q[exp_rd].dest) begin
          n_errors++;
          $display("FAIL %s_tdest[%0d]: got %h expected %h", name, exp_rd, obs_q[obs_rd].dest, exp_q[exp_rd].dest);
        end
        if (obs_q[obs_rd].user !== exp_q[exp_rd].user) begin
          n_errors++;
          $display("FAIL %s_tuser[%0d]: got %h expected %h", name, exp_rd, obs_q[obs_rd].user, exp_q[exp_rd].user);
        end
        obs_rd++;
      end
      exp_rd++;
    end
    obs_rd = obs_q.size();
  endtask

  task automatic check_credits(input string name, input int start, input int expected);
    n_checks++;
    if (credit_pulses - start !== expected) begin
      n_errors++;
      $display("FAIL %s_credits: got %0d pulses expected %0d", name, credit_pulses - start, expected);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if (axis_tvalid !== 1'b0 || axis_tdata !== '0 || axis_tlast !== 1'b0 || axis_tuser !== '0 ||
        axis_tdest !== '0 || credit_out !== 1'b0 || overflow_err !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: got tvalid=%b tlast=%b tuser=%h tdest=%h credit=%b ovf=%b tdata_nonzero=%b expected all zero",
               name, axis_tvalid, axis_tlast, axis_tuser, axis_tdest, credit_out, overflow_err, |axis_tdata);
    end
  endtask

  task automatic rebase_after_reset();
    cur_q.delete();
    exp_rd      = exp_q.size();
    obs_rd      = obs_q.size();
    sent_base   = sent_cnt;
    credit_base = credit_pulses;
  endtask

  task automatic test_reset();
    #12;
    check_outputs_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rebase_after_reset();
    cycles(2);
    check_bit("post_reset_tvalid", axis_tvalid, 1'b0);
    check_bit("post_reset_credit", credit_out, 1'b0);
  endtask

  task automatic test_single_beat();
    flit_t f;
    int c0 = credit_pulses;
    logic [TDW-1:0] exp_data;
    exp_data = {128'h4, 128'h3, 128'h2, 128'h1};
    axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f.data = FW'(i + 1);
      f.dest = 6'h2A;
      f.user = 32'hCAFE;
      f.tail = (i == 3);
      send_flit(f, 1'b1);
    end
    check_bit("latency_edge0_tvalid", axis_tvalid, 1'b0);
    cycles(1);
    check_bit("latency_edge1_tvalid", axis_tvalid, 1'b0);
    cycles(1);
    check_bit("latency_edge2_tvalid", axis_tvalid, 1'b1);
    n_checks++;
    if (axis_tdata !== exp_data || axis_tdest !== 6'h2A || axis_tuser !== 32'hCAFE || axis_tlast !== 1'b1) begin
      n_errors++;
      $display("FAIL single_fields: got tdest=%h tuser=%h tlast=%b tdata=%h expected 2a cafe 1 %h",
               axis_tdest, axis_tuser, axis_tlast, axis_tdata, exp_data);
    end
    check_beats("single", 50);
    check_credits("single", c0, 4);
  endtask

  task automatic test_multi_beat();
    int c0 = credit_pulses;
    axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_flit(rand_flit(i == 7), 1'b1);
      cycles($urandom_range(0, 2));
    end
    check_beats("multi", 100);
    check_credits("multi", c0, 8);
  endtask

  task automatic test_short_beat();
    int c0 = credit_pulses;
    logic [TDW-1:0] d;
    axis_tready = 1'b1;
    send_flit(rand_flit(1'b0), 1'b1);
    send_flit(rand_flit(1'b1), 1'b1);
    check_beats("short", 50);
    n_checks++;
    if (obs_q.size() == 0) begin
      n_errors++;
      $display("FAIL short_upper_zero: got no beat expected one");
    end else begin
      d = obs_q[obs_q.size() - 1].data;
      if (d[TDW-1:TDW/2] !== '0) begin
        n_errors++;
        $display("FAIL short_upper_zero: got %h expected 0", d[TDW-1:TDW/2]);
      end
    end
    check_credits("short", c0, 2);
  endtask

  task automatic test_random_traffic();
    int c0 = credit_pulses;
    for (int i = 0; i < 40; i++) begin
      axis_tready = ($urandom_range(0, 3) != 0);
      send_flit(rand_flit((i == 39) || ($urandom_range(0, 3) == 0)), 1'b1);
      cycles($urandom_range(0, 1));
    end
    axis_tready = 1'b1;
    check_beats("random", 400);
    check_credits("random", c0, 40);
    check_bit("random_overflow", overflow_err, 1'b0);
  endtask

  task automatic test_backpressure();
    int c0 = credit_pulses;
    axis_tready = 1'b0;
    for (int i = 0; i < 11; i++) send_flit(rand_flit(1'b0), 1'b1);
    cycles(10);
    check_credits("stall", c0, 7);
    n_checks++;
    if (credits_avail() != 0) begin
      n_errors++;
      $display("FAIL stall_credits_left: got %0d expected 0", credits_avail());
    end
    check_bit("stall_tvalid", axis_tvalid, 1'b1);
    n_checks++;
    if (axis_tdata !== exp_q[exp_rd].data) begin
      n_errors++;
      $display("FAIL stall_held_beat: got %h expected %h", axis_tdata, exp_q[exp_rd].data);
    end
    check_bit("stall_overflow", overflow_err, 1'b0);
    axis_tready = 1'b1;
    send_flit(rand_flit(1'b1), 1'b1);
    check_beats("backpressure", 100);
    check_credits("backpressure", c0, 12);
    check_bit("backpressure_overflow", overflow_err, 1'b0);
  endtask

  task automatic test_overflow();
    int c0 = credit_pulses;
    axis_tready = 1'b0;
    for (int i = 0; i < 11; i++) send_flit(rand_flit(i == 10), 1'b1);
    cycles(10);
    check_bit("pre_overflow_flag", overflow_err, 1'b0);
    send_flit(rand_flit(1'b1), 1'b0);
    check_bit("overflow_set", overflow_err, 1'b1);
    cycles(5);
    check_bit("overflow_sticky", overflow_err, 1'b1);
    axis_tready = 1'b1;
    check_beats("overflow", 100);
    check_credits("overflow", c0, 11);
    check_bit("overflow_still_set", overflow_err, 1'b1);
  endtask

  task automatic test_reset_mid_beat();
    int c0;
    axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_flit(rand_flit(1'b0), 1'b1);
    cycles(6);
    check_bit("pre_reset_tvalid", axis_tvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset_outputs");
    cycles(2);
    rst_n = 1'b1;
    rebase_after_reset();
    c0 = credit_pulses;
    axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) send_flit(rand_flit(i == 3), 1'b1);
    check_beats("after_reset", 50);
    check_credits("after_reset", c0, 4);
  endtask

  initial begin
    rst_n       = 1'b0;
    send_in     = 1'b0;
    data_in     = '0;
    dest_in     = '0;
    user_in     = '0;
    is_tail_in  = 1'b0;
    axis_tready = 1'b0;
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_short_beat();
    test_random_traffic();
    test_backpressure();
    test_overflow();
    test_reset_mid_beat();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
